pipe_reg_skid: RTL

//  Parametrised pipeline register for ALU datapath stages, with a valid/ready handshake.
//  - Full throughput: one word per clk when the consumer is ready.
//  - Holds data under back-pressure through a 2-entry skid buffer.
//  - No combinational path from out_ready to in_ready.
//  - Sits between operand fetch, ALU and result writeback.

---
 rtl/pipe_reg_skid_pkg.sv | 27 ++
 rtl/pipe_reg_skid_if.sv | 26 ++
 rtl/pipe_reg_skid_reg_en.sv | 25 ++
 rtl/pipe_reg_skid.sv | 135 +++++++++++++
 4 files changed

// File: rtl/pipe_reg_skid_pkg.sv
// Shared types and helpers for the ALU datapath pipeline registers.
package alu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Default width of the output transfer counter.
  localparam int unsigned PIPE_CNT_W_DEF = 8;

  // Largest value held by a counter of the given width.
  function automatic longint unsigned pipe_cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Occupancy reported for each state; an illegal encoding reads as empty.
  function automatic logic [1:0] state_count(input pipe_state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_reg_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: producer side (in_*)
// and consumer side (out_*).
interface pipe_reg_skid_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: drives producer data and consumer ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Pipeline register side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_reg_skid_reg_en.sv
// WIDTH-bit enabled data register with async reset and sync clear.
module reg_en #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear wins over load; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= RESET_VAL;
    else if (i_clr) r_q <= RESET_VAL;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline register with a 2-entry skid buffer: full throughput, registered
// in_ready (no out_ready -> in_ready combinational path), in-order delivery.
module pipe_reg_skid
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_reg_skid_if.slave   bus,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] PIPE_CNT_MAX = CNT_W'(pipe_cnt_max(CNT_W));

  pipe_state_t      r_state;
  pipe_state_t      w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_clr;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_fire  = bus.in_valid  & r_in_ready;
  assign w_out_fire = r_out_valid   & bus.out_ready;

  // Next state and data-register load controls; flush overrides everything.
  always_comb begin
    w_next_state = r_state;
    w_main_en    = 1'b0;
    w_skid_en    = 1'b0;
    w_clr        = 1'b0;
    w_main_d     = bus.in_data;
    if (flush) begin
      w_next_state = EMPTY;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_next_state = ONE;
            w_main_en    = 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire) begin
            w_next_state = TWO;
            w_skid_en    = 1'b1;
          end else if (w_out_fire) begin
            w_next_state = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            w_next_state = ONE;
            w_main_en    = 1'b1;
            w_main_d     = w_skid_q;
          end
        end
        default: w_next_state = EMPTY;
      endcase
    end
  end

  // State plus the registered handshake outputs, loaded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != TWO);
      r_out_valid <= (w_next_state != EMPTY);
    end
  end

  // Output transfer counter; counts through flush, cleared by reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_out_fire) begin
      r_xfer_cnt <= (r_xfer_cnt == PIPE_CNT_MAX) ? '0 : r_xfer_cnt + 1'b1;
    end
  end

  reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_clr (w_clr),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  reg_en #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_clr (w_clr),
    .i_d   (bus.in_data),
    .o_q   (w_skid_q)
  );

  // Occupancy decode from the state register.
  always_comb begin
    count = state_count(r_state);
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_main_q;
  assign xfer_cnt      = r_xfer_cnt;

endmodule
